// File: rtl/artyz7_led_sequencer.sv
// LED bank sequencer for the Arty Z7: accepts mode/pattern commands and drives
// the LEDs as off, a static pattern, a walking one or a blinking pattern,
// stepping on a prescaled tick.
module artyz7_led_sequencer #(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic                ext_clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [NUM_LEDS-1:0] cmd_pattern,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic [7:0]          step_count
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]       TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] WALK_INIT = NUM_LEDS'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  typedef enum logic [1:0] {M_OFF, M_STATIC, M_WALK, M_BLINK} mode_t;

  state_t              state_reg;
  mode_t               mode_reg;
  logic [NUM_LEDS-1:0] pattern_reg;
  logic [NUM_LEDS-1:0] led_reg;
  logic [CW-1:0]       tick_cnt_reg;
  logic [7:0]          step_reg;
  logic                ready_reg;
  logic                busy_reg;

  logic                transfer;
  logic                tick;
  logic [NUM_LEDS-1:0] walk_rot;
  logic [NUM_LEDS-1:0] load_led;
  logic [NUM_LEDS-1:0] step_led;

  assign transfer   = cmd_valid && ready_reg;
  assign tick       = (state_reg == RUN) && (tick_cnt_reg == TICK_LAST);
  assign cmd_ready  = ready_reg;
  assign busy       = busy_reg;
  assign led        = led_reg;
  assign step_count = step_reg;

  // Rotate-left wiring: the top LED wraps back into LD0.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_rot
    assign walk_rot[gi] = led_reg[(gi + NUM_LEDS - 1) % NUM_LEDS];
  end

  // Initial LED value presented when a latched command is loaded.
  always_comb begin
    load_led = '0;
    case (mode_reg)
      M_STATIC, M_BLINK: load_led = pattern_reg;
      M_WALK:            load_led = WALK_INIT;
      default:           load_led = '0;
    endcase
  end

  // LED value after one tick step in the running modes.
  always_comb begin
    step_led = led_reg;
    case (mode_reg)
      M_WALK:  step_led = walk_rot;
      M_BLINK: step_led = (led_reg == '0) ? pattern_reg : '0;
      default: step_led = led_reg;
    endcase
  end

  // Control FSM with registered outputs; a transfer in RUN always beats a tick.
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      mode_reg     <= M_OFF;
      pattern_reg  <= '0;
      led_reg      <= '0;
      tick_cnt_reg <= '0;
      step_reg     <= '0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            state_reg   <= LOAD;
            mode_reg    <= mode_t'(cmd_mode);
            pattern_reg <= cmd_pattern;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
          end else begin
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
          end
        end
        LOAD: begin
          led_reg      <= load_led;
          tick_cnt_reg <= '0;
          step_reg     <= '0;
          ready_reg    <= 1'b1;
          if (mode_reg == M_WALK || mode_reg == M_BLINK) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (transfer) begin
            state_reg   <= LOAD;
            mode_reg    <= mode_t'(cmd_mode);
            pattern_reg <= cmd_pattern;
            ready_reg   <= 1'b0;
          end else begin
            if (tick) begin
              tick_cnt_reg <= '0;
              led_reg      <= step_led;
              if (step_reg != 8'hFF) step_reg <= step_reg + 8'd1;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + CW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_artyz7_led_sequencer.sv
// Directed bench for artyz7_led_sequencer with NUM_LEDS=4, TICK_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_artyz7_led_sequencer;

  logic       ext_clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [3:0] cmd_pattern = 4'd0;
  logic [3:0] led;
  logic       busy;
  logic [7:0] step_count;

  int n_vec = 0;
  int n_miss = 0;

  localparam logic [1:0] OFF = 2'd0, STATIC = 2'd1, WALK = 2'd2, BLINK = 2'd3;

  artyz7_led_sequencer #(.NUM_LEDS(4), .TICK_CYCLES(4)) dut (
    .ext_clk    (ext_clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_pattern(cmd_pattern),
    .led        (led),
    .busy       (busy),
    .step_count (step_count)
  );

  always #5 ext_clk = ~ext_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Present one command for a single edge; returns at the falling edge inside LOAD.
  task automatic send(input logic [1:0] mode, input logic [3:0] pat);
    cmd_valid   = 1'b1;
    cmd_mode    = mode;
    cmd_pattern = pat;
    chk("send_ready", 32'(cmd_ready), 32'd1);
    @(negedge ext_clk);
    cmd_valid = 1'b0;
  endtask

  logic [3:0] walk_exp [5];

  initial begin
    walk_exp[0] = 4'b0001; walk_exp[1] = 4'b0010; walk_exp[2] = 4'b0100;
    walk_exp[3] = 4'b1000; walk_exp[4] = 4'b0001;

    // Reset state
    repeat (3) @(negedge ext_clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step", 32'(step_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge ext_clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // STATIC 1010: one LOAD cycle, then idle with led held
    send(STATIC, 4'b1010);
    chk("static_load_busy", 32'(busy), 32'd1);
    chk("static_load_ready", 32'(cmd_ready), 32'd0);
    chk("static_load_led", 32'(led), 32'd0);
    @(negedge ext_clk);
    chk("static_led", 32'(led), 32'b1010);
    chk("static_busy", 32'(busy), 32'd0);
    chk("static_ready", 32'(cmd_ready), 32'd1);
    @(negedge ext_clk);
    chk("static_hold", 32'(led), 32'b1010);

    // WALK: step every 4 cycles
    send(WALK, 4'b1111);
    @(negedge ext_clk);
    chk("walk_led0", 32'(led), 32'(walk_exp[0]));
    chk("walk_step0", 32'(step_count), 32'd0);
    chk("walk_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(negedge ext_clk);
      chk("walk_pre_tick", 32'(led), 32'(walk_exp[k-1]));
      @(negedge ext_clk);
      chk("walk_led", 32'(led), 32'(walk_exp[k]));
      chk("walk_step", 32'(step_count), 32'(k));
    end

    // Asynchronous reset mid-WALK
    @(negedge ext_clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_step", 32'(step_count), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge ext_clk);
    reset = 1'b0;
    @(negedge ext_clk);
    chk("rerst_ready", 32'(cmd_ready), 32'd1);
    chk("rerst_busy", 32'(busy), 32'd0);

    // BLINK 0110 then BLINK 0000 (abort in RUN)
    send(BLINK, 4'b0110);
    @(negedge ext_clk);
    chk("blink_led0", 32'(led), 32'b0110);
    repeat (4) @(negedge ext_clk);
    chk("blink_led1", 32'(led), 32'b0000);
    chk("blink_step1", 32'(step_count), 32'd1);
    repeat (4) @(negedge ext_clk);
    chk("blink_led2", 32'(led), 32'b0110);
    chk("blink_step2", 32'(step_count), 32'd2);
    send(BLINK, 4'b0000);
    chk("blink0_load_led", 32'(led), 32'b0110);
    @(negedge ext_clk);
    chk("blink0_led", 32'(led), 32'd0);
    chk("blink0_step0", 32'(step_count), 32'd0);
    repeat (4) @(negedge ext_clk);
    chk("blink0_led1", 32'(led), 32'd0);
    chk("blink0_step1", 32'(step_count), 32'd1);
    repeat (4) @(negedge ext_clk);
    chk("blink0_step2", 32'(step_count), 32'd2);

    // OFF during RUN clears led and returns to idle
    send(WALK, 4'b0000);
    @(negedge ext_clk);
    chk("pre_off_led", 32'(led), 32'b0001);
    repeat (2) @(negedge ext_clk);
    send(OFF, 4'b1111);
    @(negedge ext_clk);
    chk("off_led", 32'(led), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);
    chk("off_ready", 32'(cmd_ready), 32'd1);

    // Long WALK: saturation, then a command landing on a tick edge
    send(WALK, 4'b0000);
    @(negedge ext_clk);
    repeat (1016) @(negedge ext_clk);
    chk("sat_254", 32'(step_count), 32'd254);
    repeat (4) @(negedge ext_clk);
    chk("sat_255", 32'(step_count), 32'd255);
    repeat (180) @(negedge ext_clk);
    chk("sat_300", 32'(step_count), 32'd255);
    chk("sat_led", 32'(led), 32'b0001);
    repeat (3) @(negedge ext_clk);
    send(STATIC, 4'b0101);
    chk("tickcmd_load_led", 32'(led), 32'b0001);
    @(negedge ext_clk);
    chk("tickcmd_led", 32'(led), 32'b0101);
    chk("tickcmd_step", 32'(step_count), 32'd0);
    chk("tickcmd_busy", 32'(busy), 32'd0);

    // cmd_valid held across LOAD with a changing command
    cmd_valid   = 1'b1;
    cmd_mode    = STATIC;
    cmd_pattern = 4'b0011;
    @(negedge ext_clk);
    chk("hold_load1_ready", 32'(cmd_ready), 32'd0);
    cmd_pattern = 4'b1100;
    @(negedge ext_clk);
    chk("hold_led1", 32'(led), 32'b0011);
    chk("hold_ready1", 32'(cmd_ready), 32'd1);
    @(negedge ext_clk);
    chk("hold_load2_ready", 32'(cmd_ready), 32'd0);
    chk("hold_load2_led", 32'(led), 32'b0011);
    cmd_valid = 1'b0;
    @(negedge ext_clk);
    chk("hold_led2", 32'(led), 32'b1100);
    chk("hold_busy2", 32'(busy), 32'd0);
    @(negedge ext_clk);
    chk("hold_nodup_busy", 32'(busy), 32'd0);
    chk("hold_nodup_ready", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
